// File: rtl/wb_mux_pkg.sv
// Shared types and helpers for the parametrised Wishbone slave mux.
package wb_mux_pkg;

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    typedef enum logic [1:0] {RespAck, RespErr, RespRty} resp_e;

    // Ceiling log2 with a floor of 1 so single-bit fields never collapse to zero width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            w++;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_slave_mux_n_if.sv
// Host-side and peripheral-side Wishbone classic signals of the slave mux.
interface wb_slave_mux_n_if #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32
);
    localparam int unsigned SEL_W = DATA_W / 8;

    logic [ADDR_W-1:0]            wbm_adr_i;
    logic [DATA_W-1:0]            wbm_dat_i;
    logic [DATA_W-1:0]            wbm_dat_o;
    logic                         wbm_we_i;
    logic [SEL_W-1:0]             wbm_sel_i;
    logic                         wbm_stb_i;
    logic                         wbm_cyc_i;
    logic                         wbm_ack_o;
    logic                         wbm_err_o;
    logic                         wbm_rty_o;
    logic [NUM_SLAVES*ADDR_W-1:0] s_adr_o;
    logic [NUM_SLAVES*DATA_W-1:0] s_dat_o;
    logic [NUM_SLAVES*DATA_W-1:0] s_dat_i;
    logic [NUM_SLAVES-1:0]        s_we_o;
    logic [NUM_SLAVES*SEL_W-1:0]  s_sel_o;
    logic [NUM_SLAVES-1:0]        s_stb_o;
    logic [NUM_SLAVES-1:0]        s_cyc_o;
    logic [NUM_SLAVES-1:0]        s_ack_i;
    logic [NUM_SLAVES-1:0]        s_err_i;
    logic [NUM_SLAVES-1:0]        s_rty_i;
    logic [15:0]                  err_count_o;

    // The mux itself: slave of the host, master of the peripherals.
    modport slave (
        input  wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
        input  s_dat_i, s_ack_i, s_err_i, s_rty_i,
        output wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        output s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o, err_count_o
    );

    modport master (
        output wbm_adr_i, wbm_dat_i, wbm_we_i, wbm_sel_i, wbm_stb_i, wbm_cyc_i,
        output s_dat_i, s_ack_i, s_err_i, s_rty_i,
        input  wbm_dat_o, wbm_ack_o, wbm_err_o, wbm_rty_o,
        input  s_adr_o, s_dat_o, s_we_o, s_sel_o, s_stb_o, s_cyc_o, err_count_o
    );

endinterface

// File: rtl/wb_mux_addr_decode.sv
// Combinational address decode: slave index field plus a hit flag for mapped addresses.
module wb_mux_addr_decode
    import wb_mux_pkg::*;
#(
    parameter int unsigned NUM_SLAVES  = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned SLAVE_SHIFT = 8,
    localparam int unsigned IDX_W      = clog2(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0] adr,
    output logic              hit,
    output logic [IDX_W-1:0]  idx
);
    localparam int unsigned UPPER_LSB = SLAVE_SHIFT + IDX_W;

    logic [ADDR_W-1:0] upper;

    always_comb begin
        idx   = adr[SLAVE_SHIFT +: IDX_W];
        upper = adr >> UPPER_LSB;
        // Non-power-of-two slave counts leave unused index codes that must also miss.
        hit   = (upper == '0) && (32'(idx) < NUM_SLAVES);
    end

endmodule

// File: rtl/wb_slave_mux_n.sv
// Wishbone classic 1-to-N interconnect with registered decode, timeout and error counter.
module wb_slave_mux_n
    import wb_mux_pkg::*;
#(
    parameter int unsigned NUM_SLAVES     = 4,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned SLAVE_SHIFT    = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rstn,
    wb_slave_mux_n_if.slave  bus
);
    localparam int unsigned SEL_W   = DATA_W / 8;
    localparam int unsigned IDX_W   = clog2(NUM_SLAVES);
    localparam int unsigned TIMER_W = clog2(TIMEOUT_CYCLES + 1);

    state_e              state_q, state_d;
    resp_e               resp_q, resp_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [ADDR_W-1:0]   adr_q, adr_d;
    logic [DATA_W-1:0]   dat_q, dat_d;
    logic                we_q, we_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic                err_inc;

    logic                dec_hit;
    logic [IDX_W-1:0]    dec_idx;
    logic                busy;
    logic                sl_ack, sl_err, sl_rty;
    logic [DATA_W-1:0]   sl_rdata;

    wb_mux_addr_decode #(
        .NUM_SLAVES  (NUM_SLAVES),
        .ADDR_W      (ADDR_W),
        .SLAVE_SHIFT (SLAVE_SHIFT)
    ) u_decode (
        .adr (bus.wbm_adr_i),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    assign busy     = (state_q == StBusy);
    assign sl_ack   = bus.s_ack_i[idx_q];
    assign sl_err   = bus.s_err_i[idx_q];
    assign sl_rty   = bus.s_rty_i[idx_q];
    assign sl_rdata = bus.s_dat_i[32'(idx_q) * DATA_W +: DATA_W];

    always_comb begin
        state_d   = state_q;
        resp_d    = resp_q;
        idx_d     = idx_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        we_d      = we_q;
        sel_d     = sel_q;
        timer_d   = timer_q;
        rdata_d   = rdata_q;
        err_cnt_d = err_cnt_q;
        err_inc   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.wbm_cyc_i && bus.wbm_stb_i) begin
                    if (dec_hit) begin
                        idx_d   = dec_idx;
                        adr_d   = bus.wbm_adr_i;
                        dat_d   = bus.wbm_dat_i;
                        we_d    = bus.wbm_we_i;
                        sel_d   = bus.wbm_sel_i;
                        timer_d = TIMER_W'(1);
                        state_d = StBusy;
                    end else begin
                        resp_d  = RespErr;
                        err_inc = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StBusy: begin
                timer_d = timer_q + TIMER_W'(1);
                // Priority: host abort, then slave err > ack > rty, then timeout.
                if (!bus.wbm_cyc_i) begin
                    state_d = StIdle;
                end else if (sl_err) begin
                    resp_d  = RespErr;
                    state_d = StResp;
                end else if (sl_ack) begin
                    resp_d  = RespAck;
                    rdata_d = sl_rdata;
                    state_d = StResp;
                end else if (sl_rty) begin
                    resp_d  = RespRty;
                    state_d = StResp;
                end else if (timer_q == TIMER_W'(TIMEOUT_CYCLES)) begin
                    resp_d  = RespErr;
                    err_inc = 1'b1;
                    state_d = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (err_inc && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            resp_q    <= RespAck;
            idx_q     <= '0;
            adr_q     <= '0;
            dat_q     <= '0;
            we_q      <= 1'b0;
            sel_q     <= '0;
            timer_q   <= '0;
            rdata_q   <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            resp_q    <= resp_d;
            idx_q     <= idx_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            timer_q   <= timer_d;
            rdata_q   <= rdata_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.wbm_ack_o   = (state_q == StResp) && (resp_q == RespAck);
    assign bus.wbm_err_o   = (state_q == StResp) && (resp_q == RespErr);
    assign bus.wbm_rty_o   = (state_q == StResp) && (resp_q == RespRty);
    assign bus.wbm_dat_o   = rdata_q;
    assign bus.err_count_o = err_cnt_q;

    // Fan-out: only the selected slice carries the latched request, all others stay 0.
    always_comb begin
        bus.s_cyc_o = '0;
        bus.s_stb_o = '0;
        bus.s_we_o  = '0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (busy && (idx_q == IDX_W'(i))) begin
                bus.s_cyc_o[i]                  = 1'b1;
                bus.s_stb_o[i]                  = 1'b1;
                bus.s_we_o[i]                   = we_q;
                bus.s_adr_o[i*ADDR_W +: ADDR_W] = adr_q;
                bus.s_dat_o[i*DATA_W +: DATA_W] = dat_q;
                bus.s_sel_o[i*SEL_W +: SEL_W]   = sel_q;
            end
        end
    end

endmodule

// File: tb/tb_wb_slave_mux_n.sv
// Scoreboard bench for wb_slave_mux_n: 4 slaves, 256-byte windows, 16-cycle timeout.
module tb_wb_slave_mux_n;

    localparam int NS = 4;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    wb_slave_mux_n_if #(.NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32)) bus ();

    wb_slave_mux_n #(
        .NUM_SLAVES     (NS),
        .ADDR_W         (32),
        .DATA_W         (32),
        .SLAVE_SHIFT    (8),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    // Slave model: responds with resp_kind {rty,err,ack} once stb has been high resp_delay cycles.
    int          resp_delay = 0;
    logic [2:0]  resp_kind  = 3'b001;
    logic [31:0] rdata [NS];
    int          stb_cnt [NS];

    always @(posedge clk or negedge rstn) begin
        for (int i = 0; i < NS; i++) begin
            if (!rstn || !bus.s_stb_o[i]) stb_cnt[i] <= 0;
            else stb_cnt[i] <= stb_cnt[i] + 1;
        end
    end

    always_comb begin
        bus.s_ack_i = '0;
        bus.s_err_i = '0;
        bus.s_rty_i = '0;
        bus.s_dat_i = '0;
        for (int i = 0; i < NS; i++) begin
            bus.s_dat_i[i*32 +: 32] = rdata[i];
            if (bus.s_stb_o[i] && stb_cnt[i] >= resp_delay) begin
                bus.s_ack_i[i] = resp_kind[0];
                bus.s_err_i[i] = resp_kind[1];
                bus.s_rty_i[i] = resp_kind[2];
            end
        end
    end

    typedef struct {
        logic [2:0]  resp;
        logic [31:0] dat;
        int          lat;
        logic [15:0] errs;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] last_dat = '0;
    logic [15:0] exp_errs = '0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_req(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                           input logic we);
        exp_t         e;
        exp_t         o;
        logic         hit;
        int           idx;
        int           lat;
        logic [2:0]   got;
        logic [127:0] exp_dat_vec;
        logic [3:0]   exp_stb;

        hit = (adr[31:10] == '0);
        idx = int'(adr[9:8]);
        exp_dat_vec = '0;
        exp_stb = '0;
        if (hit) begin
            exp_dat_vec[idx*32 +: 32] = dat;
            exp_stb[idx] = 1'b1;
        end
        if (!hit) begin
            e.resp = 3'b010; e.lat = 1; exp_errs++;
        end else if (resp_delay >= TO) begin
            e.resp = 3'b010; e.lat = 1 + TO; exp_errs++;
        end else begin
            e.lat = 2 + resp_delay;
            if (resp_kind[1]) e.resp = 3'b010;
            else if (resp_kind[0]) begin e.resp = 3'b001; last_dat = rdata[idx]; end
            else e.resp = 3'b100;
        end
        e.dat  = last_dat;
        e.errs = exp_errs;
        sb.push_back(e);

        @(posedge clk); #1;
        bus.wbm_adr_i = adr;
        bus.wbm_dat_i = dat;
        bus.wbm_we_i  = we;
        bus.wbm_sel_i = 4'hF;
        bus.wbm_cyc_i = 1'b1;
        bus.wbm_stb_i = 1'b1;
        lat = 0;
        got = '0;
        while (got == '0 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) begin
                check_val({tag, ".stb"}, 128'(bus.s_stb_o), 128'(exp_stb));
                check_val({tag, ".sdat"}, bus.s_dat_o, exp_dat_vec);
            end
            got = {bus.wbm_rty_o, bus.wbm_err_o, bus.wbm_ack_o};
        end
        bus.wbm_cyc_i = 1'b0;
        bus.wbm_stb_i = 1'b0;
        o = sb.pop_front();
        check_val({tag, ".resp"}, 128'(got), 128'(o.resp));
        check_val({tag, ".lat"}, 128'(lat), 128'(o.lat));
        check_val({tag, ".cyc_off"}, 128'(bus.s_cyc_o), 128'(0));
        check_val({tag, ".dat_o"}, 128'(bus.wbm_dat_o), 128'(o.dat));
        check_val({tag, ".errcnt"}, 128'(bus.err_count_o), 128'(o.errs));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic pulses;
        for (int i = 0; i < NS; i++) rdata[i] = 32'hA0 + i;
        bus.wbm_adr_i = '0;
        bus.wbm_dat_i = '0;
        bus.wbm_we_i  = 1'b0;
        bus.wbm_sel_i = '0;
        bus.wbm_cyc_i = 1'b0;
        bus.wbm_stb_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.resp", 128'({bus.wbm_rty_o, bus.wbm_err_o, bus.wbm_ack_o}), 128'(0));
        check_val("rst.stb", 128'(bus.s_stb_o), 128'(0));
        check_val("rst.errcnt", 128'(bus.err_count_o), 128'(0));
        check_val("rst.dat_o", 128'(bus.wbm_dat_o), 128'(0));
        rstn = 1'b1;

        resp_delay = 0;  resp_kind = 3'b001;
        run_req("wr_tied_ack", 32'h0000_0104, 32'h1122_3344, 1'b1);

        rdata[2] = 32'hDEAD_BEEF;
        resp_delay = 3;
        run_req("rd_delay3", 32'h0000_0200, 32'h0, 1'b0);

        run_req("miss_upper", 32'hFF00_0104, 32'h0, 1'b0);
        run_req("miss_idx4", 32'h0000_0400, 32'h0, 1'b0);

        resp_delay = 1000;
        run_req("timeout", 32'h0000_0300, 32'h0, 1'b0);

        resp_delay = 0;  resp_kind = 3'b011;
        run_req("ack_err", 32'h0000_0000, 32'h0, 1'b0);
        resp_kind = 3'b101;
        run_req("ack_rty", 32'h0000_0100, 32'h0, 1'b0);
        resp_kind = 3'b100;
        run_req("rty", 32'h0000_0300, 32'h0, 1'b0);

        // Host abort while the slave stalls.
        resp_delay = 1000;  resp_kind = 3'b001;
        @(posedge clk); #1;
        bus.wbm_adr_i = 32'h0000_0100;
        bus.wbm_cyc_i = 1'b1;
        bus.wbm_stb_i = 1'b1;
        @(posedge clk); #1;
        check_val("abort.busy_cyc", 128'(bus.s_cyc_o), 128'(4'b0010));
        bus.wbm_cyc_i = 1'b0;
        bus.wbm_stb_i = 1'b0;
        pulses = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (k == 0) check_val("abort.cyc_low", 128'(bus.s_cyc_o), 128'(0));
            pulses = pulses | bus.wbm_ack_o | bus.wbm_err_o | bus.wbm_rty_o;
        end
        check_val("abort.no_pulse", 128'(pulses), 128'(0));
        check_val("abort.errcnt", 128'(bus.err_count_o), 128'(exp_errs));

        // Asynchronous reset in the middle of a BUSY cycle.
        bus.wbm_adr_i = 32'h0000_0300;
        bus.wbm_cyc_i = 1'b1;
        bus.wbm_stb_i = 1'b1;
        @(posedge clk); #1;
        check_val("arst.busy_stb", 128'(bus.s_stb_o), 128'(4'b1000));
        #2 rstn = 1'b0;
        #1;
        check_val("arst.stb", 128'(bus.s_stb_o), 128'(0));
        check_val("arst.cyc", 128'(bus.s_cyc_o), 128'(0));
        check_val("arst.sadr", bus.s_adr_o, 128'(0));
        check_val("arst.errcnt", 128'(bus.err_count_o), 128'(0));
        check_val("arst.dat_o", 128'(bus.wbm_dat_o), 128'(0));
        bus.wbm_cyc_i = 1'b0;
        bus.wbm_stb_i = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
